// File: rtl/multicycle_controller_if.sv
// Bundles the multicycle controller's instruction-side inputs and datapath control outputs.
// master = controller, slave = datapath/IR side.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       lt;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       mem_req;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal_op;

  modport master (
    input  opcode, funct3, zero, lt, mem_ready,
    output PCWrite, AdrSrc, mem_req, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op
  );

  modport slave (
    output opcode, funct3, zero, lt, mem_ready,
    input  PCWrite, AdrSrc, mem_req, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences each instruction over
// 3-5 states and stretches memory states by either mem_ready or a fixed wait count.
module multicycle_controller #(
  parameter int USE_READY = 1,
  parameter int MEM_WAIT  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, JAL, JALRADR, BRANCH, LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

  state_t     state;
  state_t     next;
  logic       valid;
  logic [3:0] cnt;
  logic       done;
  logic       known_op;
  logic       take;
  logic [2:0] imm_sel;

  logic       mem_req_q;
  logic       adr_src_q;
  logic       mem_write_q;
  logic       reg_write_q;
  logic [1:0] result_src_q;
  logic [1:0] alu_src_a_q;
  logic [1:0] alu_src_b_q;
  logic [1:0] alu_op_q;

  always_comb begin
    if (USE_READY != 0) done = bus.mem_ready;
    else                done = (cnt == WAIT_LIMIT);
  end

  always_comb begin
    known_op = 1'b1;
    imm_sel  = 3'b000;
    case (bus.opcode)
      OP_LOAD, OP_RTYPE, OP_ITYPE, OP_JALR: imm_sel = 3'b000;
      OP_STORE:  imm_sel = 3'b001;
      OP_BRANCH: imm_sel = 3'b010;
      OP_JAL:    imm_sel = 3'b011;
      OP_LUI:    imm_sel = 3'b100;
      default:   known_op = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  take = bus.zero;
      3'b001:  take = !bus.zero;
      3'b100:  take = bus.lt;
      3'b101:  take = !bus.lt;
      default: take = 1'b0;
    endcase
  end

  // valid stays low for one cycle after reset so the first fetch starts a cycle later.
  always_comb begin
    next = state;
    case (state)
      FETCH:    if (done) next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: next = MEMADR;
          OP_RTYPE:          next = EXECR;
          OP_ITYPE:          next = EXECI;
          OP_JAL:            next = JAL;
          OP_JALR:           next = JALRADR;
          OP_BRANCH:         next = BRANCH;
          OP_LUI:            next = LUI;
          default:           next = FETCH;
        endcase
      end
      MEMADR:   next = (bus.opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (done) next = MEMWB;
      MEMWB:    next = FETCH;
      MEMWRITE: if (done) next = FETCH;
      EXECR:    next = ALUWB;
      EXECI:    next = ALUWB;
      ALUWB:    next = FETCH;
      JAL:      next = ALUWB;
      JALRADR:  next = JAL;
      BRANCH:   next = FETCH;
      LUI:      next = FETCH;
      default:  next = FETCH;
    endcase
    if (!valid) next = FETCH;
  end

  // Moore outputs are registered from the decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      valid        <= 1'b0;
      cnt          <= 4'd0;
      mem_req_q    <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 2'b00;
    end else begin
      valid        <= 1'b1;
      state        <= next;
      cnt          <= (!valid || next != state) ? 4'd0 : cnt + 4'd1;
      mem_req_q    <= 1'b0;
      adr_src_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= 2'b00;
      case (next)
        FETCH: begin
          mem_req_q    <= 1'b1;
          result_src_q <= 2'b10;
          alu_src_b_q  <= 2'b10;
        end
        DECODE: begin
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b01;
        end
        MEMADR, EXECI, JALRADR: begin
          alu_src_a_q <= 2'b10;
          alu_src_b_q <= 2'b01;
          if (next == EXECI) alu_op_q <= 2'b11;
        end
        MEMREAD: begin
          mem_req_q <= 1'b1;
          adr_src_q <= 1'b1;
        end
        MEMWB: begin
          result_src_q <= 2'b01;
          reg_write_q  <= 1'b1;
        end
        MEMWRITE: begin
          mem_req_q   <= 1'b1;
          adr_src_q   <= 1'b1;
          mem_write_q <= 1'b1;
        end
        EXECR: begin
          alu_src_a_q <= 2'b10;
          alu_op_q    <= 2'b10;
        end
        ALUWB:  reg_write_q <= 1'b1;
        JAL: begin
          alu_src_a_q <= 2'b01;
          alu_src_b_q <= 2'b10;
        end
        BRANCH: begin
          alu_src_a_q <= 2'b10;
          alu_op_q    <= 2'b01;
        end
        LUI: begin
          result_src_q <= 2'b11;
          reg_write_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.AdrSrc     = adr_src_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.ResultSrc  = result_src_q;
  assign bus.ALUSrcA    = alu_src_a_q;
  assign bus.ALUSrcB    = alu_src_b_q;
  assign bus.ALUOp      = alu_op_q;
  assign bus.IRWrite    = valid && (state == FETCH) && done;
  assign bus.PCWrite    = valid && (((state == FETCH) && done) || (state == JAL) ||
                                     ((state == BRANCH) && take));
  assign bus.illegal_op = valid && (state == DECODE) && !known_op;
  assign bus.ImmSrc     = valid ? imm_sel : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: a per-cycle vector table on a mem_ready-driven controller, plus
// hand sequences for the fixed-wait variant and reset abort during a store.
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  logic rst_cnt_n;
  int   checks;
  int   errors;

  multicycle_controller_if bus_rdy();
  multicycle_controller_if bus_cnt();

  multicycle_controller #(.USE_READY(1), .MEM_WAIT(0)) dut_rdy (
    .clk(clk), .rst_n(rst_n), .bus(bus_rdy)
  );

  multicycle_controller #(.USE_READY(0), .MEM_WAIT(2)) dut_cnt (
    .clk(clk), .rst_n(rst_cnt_n), .bus(bus_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [17:0] act_rdy;
  logic [17:0] act_cnt;
  assign act_rdy = {bus_rdy.PCWrite, bus_rdy.AdrSrc, bus_rdy.mem_req, bus_rdy.MemWrite,
                    bus_rdy.IRWrite, bus_rdy.RegWrite, bus_rdy.ResultSrc, bus_rdy.ALUSrcA,
                    bus_rdy.ALUSrcB, bus_rdy.ALUOp, bus_rdy.ImmSrc, bus_rdy.illegal_op};
  assign act_cnt = {bus_cnt.PCWrite, bus_cnt.AdrSrc, bus_cnt.mem_req, bus_cnt.MemWrite,
                    bus_cnt.IRWrite, bus_cnt.RegWrite, bus_cnt.ResultSrc, bus_cnt.ALUSrcA,
                    bus_cnt.ALUSrcB, bus_cnt.ALUOp, bus_cnt.ImmSrc, bus_cnt.illegal_op};

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        mem_ready;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output word: {PCWrite,AdrSrc,mem_req,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,illegal_op}
  function automatic logic [17:0] o(input logic pcw, input logic adr, input logic req,
                                    input logic mw, input logic irw, input logic rw,
                                    input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] op,
                                    input logic [2:0] imm, input logic ill);
    return {pcw, adr, req, mw, irw, rw, rs, sa, sb, op, imm, ill};
  endfunction

  function automatic logic [17:0] e_fetch(input logic d, input logic [2:0] imm);
    return o(d, 0, 1, 0, d, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [2:0] imm, input logic ill);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, ill);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_memread(input logic [2:0] imm);
    return o(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_memwb(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_memwrite(input logic [2:0] imm);
    return o(0, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_execr(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 0);
  endfunction
  function automatic logic [17:0] e_execi(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, imm, 0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_jal(input logic [2:0] imm);
    return o(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_jalradr(input logic [2:0] imm);
    return o(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0);
  endfunction
  function automatic logic [17:0] e_branch(input logic t);
    return o(t, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 0);
  endfunction
  function automatic logic [17:0] e_lui();
    return o(0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 0);
  endfunction

  function automatic vec_t v(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input logic l, input logic mr, input logic [17:0] e);
    vec_t r;
    r.opcode = op; r.funct3 = f3; r.zero = z; r.lt = l; r.mem_ready = mr; r.exp = e;
    return r;
  endfunction

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic z,
                               input logic l, input logic mr);
    bus_rdy.opcode    = op;
    bus_rdy.funct3    = f3;
    bus_rdy.zero      = z;
    bus_rdy.lt        = l;
    bus_rdy.mem_ready = mr;
  endtask

  task automatic checkOutput(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111, JR = 7'b1100111, BR = 7'b1100011, LU = 7'b0110111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic [17:0] sw_exp[8];
  int irw_cnt;
  int mw_cnt;

  initial begin
    checks = 0;
    errors = 0;

    // R-type, then lw with three not-ready cycles in MEMREAD
    vecs.push_back(v(RT, 0, 0, 0, 1, e_fetch(1, 3'b000)));
    vecs.push_back(v(RT, 0, 0, 0, 1, e_decode(3'b000, 0)));
    vecs.push_back(v(RT, 0, 0, 0, 1, e_execr(3'b000)));
    vecs.push_back(v(RT, 0, 0, 0, 1, e_aluwb(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 1, e_fetch(1, 3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 1, e_decode(3'b000, 0)));
    vecs.push_back(v(LW, 0, 0, 0, 0, e_memadr(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 0, e_memread(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 0, e_memread(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 0, e_memread(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 1, e_memread(3'b000)));
    vecs.push_back(v(LW, 0, 0, 0, 0, e_memwb(3'b000)));
    // sw completing in the entry cycle of MEMWRITE; one stalled fetch first
    vecs.push_back(v(SW, 0, 0, 0, 0, e_fetch(0, 3'b001)));
    vecs.push_back(v(SW, 0, 0, 0, 1, e_fetch(1, 3'b001)));
    vecs.push_back(v(SW, 0, 0, 0, 1, e_decode(3'b001, 0)));
    vecs.push_back(v(SW, 0, 0, 0, 1, e_memadr(3'b001)));
    vecs.push_back(v(SW, 0, 0, 0, 1, e_memwrite(3'b001)));
    vecs.push_back(v(IT, 0, 0, 0, 1, e_fetch(1, 3'b000)));
    vecs.push_back(v(IT, 0, 0, 0, 1, e_decode(3'b000, 0)));
    vecs.push_back(v(IT, 0, 0, 0, 1, e_execi(3'b000)));
    vecs.push_back(v(IT, 0, 0, 0, 1, e_aluwb(3'b000)));
    vecs.push_back(v(JL, 0, 0, 0, 1, e_fetch(1, 3'b011)));
    vecs.push_back(v(JL, 0, 0, 0, 1, e_decode(3'b011, 0)));
    vecs.push_back(v(JL, 0, 0, 0, 1, e_jal(3'b011)));
    vecs.push_back(v(JL, 0, 0, 0, 1, e_aluwb(3'b011)));
    vecs.push_back(v(JR, 0, 0, 0, 1, e_fetch(1, 3'b000)));
    vecs.push_back(v(JR, 0, 0, 0, 1, e_decode(3'b000, 0)));
    vecs.push_back(v(JR, 0, 0, 0, 1, e_jalradr(3'b000)));
    vecs.push_back(v(JR, 0, 0, 0, 1, e_jal(3'b000)));
    vecs.push_back(v(JR, 0, 0, 0, 1, e_aluwb(3'b000)));
    // branches: bne taken, beq not taken, bge with lt=1, funct3=010, blt taken, beq taken
    vecs.push_back(v(BR, 3'b001, 0, 0, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b001, 0, 0, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b001, 0, 0, 1, e_branch(1)));
    vecs.push_back(v(BR, 3'b000, 0, 0, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b000, 0, 0, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b000, 0, 0, 1, e_branch(0)));
    vecs.push_back(v(BR, 3'b101, 0, 1, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b101, 0, 1, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b101, 0, 1, 1, e_branch(0)));
    vecs.push_back(v(BR, 3'b010, 1, 1, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b010, 1, 1, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b010, 1, 1, 1, e_branch(0)));
    vecs.push_back(v(BR, 3'b100, 0, 1, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b100, 0, 1, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b100, 0, 1, 1, e_branch(1)));
    vecs.push_back(v(BR, 3'b000, 1, 0, 1, e_fetch(1, 3'b010)));
    vecs.push_back(v(BR, 3'b000, 1, 0, 1, e_decode(3'b010, 0)));
    vecs.push_back(v(BR, 3'b000, 1, 0, 1, e_branch(1)));
    vecs.push_back(v(LU, 0, 0, 0, 1, e_fetch(1, 3'b100)));
    vecs.push_back(v(LU, 0, 0, 0, 1, e_decode(3'b100, 0)));
    vecs.push_back(v(LU, 0, 0, 0, 1, e_lui()));
    vecs.push_back(v(BAD, 0, 0, 0, 1, e_fetch(1, 3'b000)));
    vecs.push_back(v(BAD, 0, 0, 0, 1, e_decode(3'b000, 1)));
    vecs.push_back(v(RT, 0, 0, 0, 1, e_fetch(1, 3'b000)));

    sw_exp[0] = e_fetch(0, 3'b001);
    sw_exp[1] = e_fetch(0, 3'b001);
    sw_exp[2] = e_fetch(1, 3'b001);
    sw_exp[3] = e_decode(3'b001, 0);
    sw_exp[4] = e_memadr(3'b001);
    sw_exp[5] = e_memwrite(3'b001);
    sw_exp[6] = e_memwrite(3'b001);
    sw_exp[7] = e_memwrite(3'b001);

    rst_n     = 1'b0;
    rst_cnt_n = 1'b0;
    applyStimulus(RT, 3'b000, 1'b0, 1'b0, 1'b1);
    bus_cnt.opcode    = SW;
    bus_cnt.funct3    = 3'b000;
    bus_cnt.zero      = 1'b0;
    bus_cnt.lt        = 1'b0;
    bus_cnt.mem_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_rdy", act_rdy, 18'd0);
    checkOutput("reset_cnt", act_cnt, 18'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("release_idle", act_rdy, 18'd0);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].opcode, vecs[i].funct3, vecs[i].zero, vecs[i].lt, vecs[i].mem_ready);
      #1 checkOutput($sformatf("vec%0d", i), act_rdy, vecs[i].exp);
      @(negedge clk);
    end

    // Fixed-wait controller (MEM_WAIT=2): full sw, mem_ready held high and ignored
    rst_cnt_n = 1'b1;
    #1 checkOutput("cnt_release_idle", act_cnt, 18'd0);
    @(negedge clk);
    irw_cnt = 0;
    mw_cnt  = 0;
    for (int i = 0; i < 8; i++) begin
      #1 checkOutput($sformatf("cnt_sw%0d", i), act_cnt, sw_exp[i]);
      irw_cnt += int'(bus_cnt.IRWrite);
      mw_cnt  += int'(bus_cnt.MemWrite);
      @(negedge clk);
    end
    checks++;
    if (irw_cnt != 1) begin
      errors++;
      $display("[TB] FAIL cnt_irwrite_count: got=%0d expected=1", irw_cnt);
    end
    checks++;
    if (mw_cnt != 3) begin
      errors++;
      $display("[TB] FAIL cnt_memwrite_count: got=%0d expected=3", mw_cnt);
    end

    // Second sw, aborted by reset in the first MEMWRITE cycle
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput($sformatf("cnt_sw2_%0d", i), act_cnt, sw_exp[i]);
      if (i < 5) @(negedge clk);
    end
    #2 rst_cnt_n = 1'b0;
    #1 checkOutput("abort_immediate", act_cnt, 18'd0);
    @(negedge clk);
    #1 checkOutput("abort_held", act_cnt, 18'd0);
    rst_cnt_n = 1'b1;
    #1 checkOutput("abort_release_idle", act_cnt, 18'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput($sformatf("abort_fetch%0d", i), act_cnt, sw_exp[i]);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
